button_hand_mover: RTL and testbench
====================================

# button_hand_mover

Converts the four raw board pushbuttons into debounced, auto-repeating motion of the left-hand saber, producing the bottom/top endpoint coordinates consumed by the game logic and renderer. It is the test-mode stand-in for camera tracking: it feeds the left-hand coordinate ports directly, so its outputs are in screen pixel space (1024x768).

## Interface

Parameters:
- DEBOUNCE_CYCLES, 650000: cycles a synced input must be stable before the debounced level changes (10 ms at 65 MHz)
- REPEAT_DELAY, 32500000: cycles from press-step to first auto-repeat step (0.5 s)
- REPEAT_PERIOD, 1083333: cycles between auto-repeat steps (~60 Hz)
- STEP, 8: pixels moved per step
- X_MAX, 1023 / Y_MAX, 767: upper clamp for bottom endpoint
- HAND_LEN, 100: top endpoint sits HAND_LEN pixels above bottom (smaller y)
- START_X, 512 / START_Y, 384: reset position of bottom endpoint
- Z_DEFAULT, 14'd1000: constant depth for both endpoints

Ports:
- clk_in  input  1  system clock (65 MHz pixel clock)
- rst_in  input  1  synchronous, active-high reset
- left_button, right_button, up_button, down_button  input  1 each  raw asynchronous buttons, active-high
- hand_x_left_bottom  output  12  bottom x
- hand_y_left_bottom  output  12  bottom y
- hand_z_left_bottom  output  14  bottom z
- hand_x_left_top  output  12  top x
- hand_y_left_top  output  12  top y
- hand_z_left_top  output  14  top z
- move_valid_out  output  1  one-cycle pulse, high in the cycle new coordinates first appear

## Operation

- Sync: each button through a 2-flop synchronizer.
- Debounce per button: counter clears whenever synced level equals debounced level; otherwise increments; when it reaches DEBOUNCE_CYCLES-1 the debounced level flips and counter clears.
- Repeat FSM per button, states IDLE, HOLD, REPEAT:
  - IDLE: debounced rising edge -> emit step pulse, load timer REPEAT_DELAY-1, go HOLD.
  - HOLD: timer decrements; at 0 -> emit step, load REPEAT_PERIOD-1, go REPEAT.
  - REPEAT: timer decrements; at 0 -> emit step, reload REPEAT_PERIOD-1.
  - Any state: debounced level low -> IDLE, no step that cycle.
- Step combine: dx = STEP*(right_step - left_step), dy = STEP*(down_step - up_step); opposite steps in the same cycle cancel on that axis; both axes may move in one cycle.
- Arithmetic in 14-bit signed; clamp bottom x to [0, X_MAX], bottom y to [HAND_LEN, Y_MAX] (keeps top y >= 0). No wrap ever.
- Top x = bottom x; top y = bottom y - HAND_LEN; both z = Z_DEFAULT.
- move_valid_out pulses whenever any step pulse occurred, even if clamping leaves coordinates unchanged.

## Timing

- All outputs registered.
- Reset values: bottom (START_X, START_Y), top (START_X, START_Y-HAND_LEN), z = Z_DEFAULT, move_valid_out 0; debounced levels 0, FSMs IDLE, all counters 0.
- Latency: raw edge at cycle 0 -> synced at 2 -> debounced flips at 2+DEBOUNCE_CYCLES -> step pulse at 3+DEBOUNCE_CYCLES -> coordinates and move_valid_out at 4+DEBOUNCE_CYCLES.
- Held button: steps at press-step, press-step+REPEAT_DELAY, then every REPEAT_PERIOD.
- Glitch shorter than DEBOUNCE_CYCLES: no step.
- Reset mid-hold: FSM to IDLE, debounced level 0; a button still held after reset re-debounces and produces exactly one fresh press-step.
- Reset overrides all steps in the same cycle.

## Test plan

Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, STEP=8.
- Reset -> bottom (512,384), top (512,284), z 1000, move_valid_out 0.
- Hold right 10 cycles then release -> exactly one move_valid_out pulse 8 cycles after press; x = 520; y unchanged.
- Hold up 60 cycles -> steps at press-step +0, +20, +25, +30, ...; y decreases by 8 each; top y tracks bottom-100.
- Toggle left every 2 cycles for 40 cycles -> no move_valid_out, x stays 512.
- Left and right pressed same cycle -> move_valid_out pulses, x unchanged; down alone from y=764 -> y clamps to 767; up from y=104 -> y clamps to 100, top y 0.
- Hold down, assert rst_in 1 cycle mid-REPEAT while still holding -> outputs return to reset values, then one step after debounce, first repeat 20 cycles later.

Source files
------------

// File: rtl/button_hand_mover.sv
// Test-mode left-hand saber driver: four raw pushbuttons are synchronized, debounced
// and auto-repeated into clamped bottom/top endpoint coordinates in screen pixel space.
module button_hand_mover #(
   parameter int          DEBOUNCE_CYCLES = 650000,
   parameter int          REPEAT_DELAY    = 32500000,
   parameter int          REPEAT_PERIOD   = 1083333,
   parameter int          STEP            = 8,
   parameter int          X_MAX           = 1023,
   parameter int          Y_MAX           = 767,
   parameter int          HAND_LEN        = 100,
   parameter int          START_X         = 512,
   parameter int          START_Y         = 384,
   parameter logic [13:0] Z_DEFAULT       = 14'd1000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        left_button,
   input  logic        right_button,
   input  logic        up_button,
   input  logic        down_button,
   output logic [11:0] hand_x_left_bottom,
   output logic [11:0] hand_y_left_bottom,
   output logic [13:0] hand_z_left_bottom,
   output logic [11:0] hand_x_left_top,
   output logic [11:0] hand_y_left_top,
   output logic [13:0] hand_z_left_top,
   output logic        move_valid_out
);

   localparam int DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TMR_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

   localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0]  DB_ONE      = DB_W'(1);
   localparam logic [TMR_W-1:0] DELAY_LOAD  = TMR_W'(REPEAT_DELAY - 1);
   localparam logic [TMR_W-1:0] PERIOD_LOAD = TMR_W'(REPEAT_PERIOD - 1);
   localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   localparam logic signed [13:0] STEP_S  = 14'(STEP);
   localparam logic signed [13:0] ZERO_S  = 14'sd0;
   localparam logic signed [13:0] X_MAX_S = 14'(X_MAX);
   localparam logic signed [13:0] Y_MAX_S = 14'(Y_MAX);
   localparam logic signed [13:0] Y_MIN_S = 14'(HAND_LEN);

   localparam logic [11:0] START_X_U     = 12'(START_X);
   localparam logic [11:0] START_Y_U     = 12'(START_Y);
   localparam logic [11:0] START_TOP_Y_U = 12'(START_Y - HAND_LEN);
   localparam logic [11:0] HAND_LEN_U    = 12'(HAND_LEN);

   // Button lanes: 0 left, 1 right, 2 up, 3 down
   logic [3:0]       raw_s;
   logic [3:0]       sync1_r;
   logic [3:0]       sync2_r;
   logic [3:0]       deb_r;
   logic [3:0]       step_r;
   logic [DB_W-1:0]  db_cnt_r [4];
   logic [TMR_W-1:0] tmr_r    [4];
   logic [1:0]       state_r  [4];

   logic signed [13:0] dx_s;
   logic signed [13:0] dy_s;
   logic signed [13:0] x_sum_s;
   logic signed [13:0] y_sum_s;
   logic [11:0]        x_next_s;
   logic [11:0]        y_next_s;

   logic [11:0] x_r;
   logic [11:0] y_r;
   logic [11:0] top_y_r;
   logic [13:0] z_r;
   logic        move_valid_r;

   assign raw_s = {down_button, up_button, right_button, left_button};

   // Two-flop synchronizer for the asynchronous buttons
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync1_r <= 4'b0000;
         sync2_r <= 4'b0000;
      end else begin
         sync1_r <= raw_s;
         sync2_r <= sync1_r;
      end
   end

   // Per-button debounce counter and IDLE/HOLD/REPEAT auto-repeat machine
   always_ff @(posedge clk_in) begin
      for (int i = 0; i < 4; i++) begin
         if (rst_in) begin
            deb_r[i]    <= 1'b0;
            db_cnt_r[i] <= '0;
            tmr_r[i]    <= '0;
            state_r[i]  <= ST_IDLE;
            step_r[i]   <= 1'b0;
         end else begin
            if (sync2_r[i] == deb_r[i]) begin
               db_cnt_r[i] <= '0;
            end else if (db_cnt_r[i] == DB_LAST) begin
               deb_r[i]    <= sync2_r[i];
               db_cnt_r[i] <= '0;
            end else begin
               db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
            end

            step_r[i] <= 1'b0;
            // A low debounced level wins over any pending timer expiry
            case (state_r[i])
               ST_IDLE: begin
                  if (deb_r[i]) begin
                     step_r[i]  <= 1'b1;
                     tmr_r[i]   <= DELAY_LOAD;
                     state_r[i] <= ST_HOLD;
                  end
               end
               ST_HOLD, ST_REPEAT: begin
                  if (!deb_r[i]) begin
                     state_r[i] <= ST_IDLE;
                  end else if (tmr_r[i] == '0) begin
                     step_r[i]  <= 1'b1;
                     tmr_r[i]   <= PERIOD_LOAD;
                     state_r[i] <= ST_REPEAT;
                  end else begin
                     tmr_r[i] <= tmr_r[i] - TMR_ONE;
                  end
               end
               default: begin
                  state_r[i] <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Combine step pulses into a signed move and clamp so no coordinate ever wraps
   always_comb begin
      dx_s     = ZERO_S;
      dy_s     = ZERO_S;
      x_sum_s  = ZERO_S;
      y_sum_s  = ZERO_S;
      x_next_s = x_r;
      y_next_s = y_r;

      case ({step_r[1], step_r[0]})
         2'b10:   dx_s = STEP_S;
         2'b01:   dx_s = -STEP_S;
         default: dx_s = ZERO_S;
      endcase
      case ({step_r[3], step_r[2]})
         2'b10:   dy_s = STEP_S;
         2'b01:   dy_s = -STEP_S;
         default: dy_s = ZERO_S;
      endcase

      x_sum_s = $signed({2'b00, x_r}) + dx_s;
      y_sum_s = $signed({2'b00, y_r}) + dy_s;

      if (x_sum_s < ZERO_S) begin
         x_next_s = 12'd0;
      end else if (x_sum_s > X_MAX_S) begin
         x_next_s = X_MAX_S[11:0];
      end else begin
         x_next_s = x_sum_s[11:0];
      end

      // Lower y bound of HAND_LEN keeps the top endpoint on screen
      if (y_sum_s < Y_MIN_S) begin
         y_next_s = Y_MIN_S[11:0];
      end else if (y_sum_s > Y_MAX_S) begin
         y_next_s = Y_MAX_S[11:0];
      end else begin
         y_next_s = y_sum_s[11:0];
      end
   end

   // Registered coordinates, depth and move strobe
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         x_r          <= START_X_U;
         y_r          <= START_Y_U;
         top_y_r      <= START_TOP_Y_U;
         z_r          <= Z_DEFAULT;
         move_valid_r <= 1'b0;
      end else begin
         x_r          <= x_next_s;
         y_r          <= y_next_s;
         top_y_r      <= y_next_s - HAND_LEN_U;
         z_r          <= Z_DEFAULT;
         move_valid_r <= |step_r;
      end
   end

   assign hand_x_left_bottom = x_r;
   assign hand_y_left_bottom = y_r;
   assign hand_z_left_bottom = z_r;
   assign hand_x_left_top    = x_r;
   assign hand_y_left_top    = top_y_r;
   assign hand_z_left_top    = z_r;
   assign move_valid_out     = move_valid_r;

endmodule

// File: tb/tb_button_hand_mover.sv
// Directed bench for button_hand_mover with short debounce/repeat timings;
// expected cycles and coordinates are worked out by hand from the pulse timeline.
module tb_button_hand_mover;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        left_b = 1'b0;
   logic        right_b = 1'b0;
   logic        up_b = 1'b0;
   logic        down_b = 1'b0;
   logic [11:0] xb, yb, xt, yt;
   logic [13:0] zb, zt;
   logic        mv;

   int n_cmp = 0;
   int n_bad = 0;
   int pulse_cnt = 0;
   int pulse_at [8];

   always #5 clk = ~clk;

   button_hand_mover #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(20),
      .REPEAT_PERIOD(5),
      .STEP(8)
   ) dut (
      .clk_in(clk),
      .rst_in(rst),
      .left_button(left_b),
      .right_button(right_b),
      .up_button(up_b),
      .down_button(down_b),
      .hand_x_left_bottom(xb),
      .hand_y_left_bottom(yb),
      .hand_z_left_bottom(zb),
      .hand_x_left_top(xt),
      .hand_y_left_top(yt),
      .hand_z_left_top(zt),
      .move_valid_out(mv)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic clear_pulses();
      pulse_cnt = 0;
      for (int k = 0; k < 8; k++) pulse_at[k] = -1;
   endtask

   // Advance into cycle cyc and log it if the move strobe is high there
   task automatic tick(input int cyc);
      @(posedge clk);
      #1;
      if (mv === 1'b1) begin
         if (pulse_cnt < 8) pulse_at[pulse_cnt] = cyc;
         pulse_cnt++;
      end
   endtask

   initial begin
      clear_pulses();
      for (int c = 0; c < 3; c++) tick(c + 1);
      check_eq("rst_xb", 32'(xb), 32'd512);
      check_eq("rst_yb", 32'(yb), 32'd384);
      check_eq("rst_zb", 32'(zb), 32'd1000);
      check_eq("rst_xt", 32'(xt), 32'd512);
      check_eq("rst_yt", 32'(yt), 32'd284);
      check_eq("rst_zt", 32'(zt), 32'd1000);
      check_eq("rst_mv", 32'(mv), 32'd0);
      rst = 1'b0;
      tick(0);

      // right held cycles 0..9: single press step, strobe in cycle 8
      clear_pulses();
      right_b = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (c == 10) right_b = 1'b0;
         tick(c + 1);
      end
      check_eq("right_pulses", 32'(pulse_cnt), 32'd1);
      check_eq("right_first", 32'(pulse_at[0]), 32'd8);
      check_eq("right_xb", 32'(xb), 32'd520);
      check_eq("right_xt", 32'(xt), 32'd520);
      check_eq("right_yb", 32'(yb), 32'd384);

      // up held cycles 0..59: steps 8, 28, 33..58, plus one more at 63 before release settles
      clear_pulses();
      up_b = 1'b1;
      for (int c = 0; c < 80; c++) begin
         if (c == 60) up_b = 1'b0;
         tick(c + 1);
         if (c + 1 == 60) check_eq("up_pulses_held", 32'(pulse_cnt), 32'd8);
      end
      check_eq("up_p0", 32'(pulse_at[0]), 32'd8);
      check_eq("up_p1", 32'(pulse_at[1]), 32'd28);
      check_eq("up_p2", 32'(pulse_at[2]), 32'd33);
      check_eq("up_p7", 32'(pulse_at[7]), 32'd58);
      check_eq("up_pulses", 32'(pulse_cnt), 32'd9);
      check_eq("up_yb", 32'(yb), 32'd312);
      check_eq("up_yt", 32'(yt), 32'd212);

      // left toggling every 2 cycles never survives the debounce
      clear_pulses();
      for (int c = 0; c < 50; c++) begin
         left_b = (c < 40) ? (((c / 2) % 2) == 0) : 1'b0;
         tick(c + 1);
      end
      check_eq("glitch_pulses", 32'(pulse_cnt), 32'd0);
      check_eq("glitch_xb", 32'(xb), 32'd520);

      // left and right together cancel but still strobe
      clear_pulses();
      left_b = 1'b1;
      right_b = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (c == 10) begin
            left_b = 1'b0;
            right_b = 1'b0;
         end
         tick(c + 1);
      end
      check_eq("lr_pulses", 32'(pulse_cnt), 32'd1);
      check_eq("lr_first", 32'(pulse_at[0]), 32'd8);
      check_eq("lr_xb", 32'(xb), 32'd520);
      check_eq("lr_yb", 32'(yb), 32'd312);

      // down held 400 cycles: 77 steps from y=312 saturate at 767, strobes continue
      clear_pulses();
      down_b = 1'b1;
      for (int c = 0; c < 420; c++) begin
         if (c == 400) down_b = 1'b0;
         tick(c + 1);
      end
      check_eq("down_pulses", 32'(pulse_cnt), 32'd77);
      check_eq("down_yb", 32'(yb), 32'd767);
      check_eq("down_yt", 32'(yt), 32'd667);
      check_eq("down_xb", 32'(xb), 32'd520);

      // up held 500 cycles: 97 steps from 767 saturate at 100, top at 0
      clear_pulses();
      up_b = 1'b1;
      for (int c = 0; c < 520; c++) begin
         if (c == 500) up_b = 1'b0;
         tick(c + 1);
      end
      check_eq("upclamp_pulses", 32'(pulse_cnt), 32'd97);
      check_eq("upclamp_yb", 32'(yb), 32'd100);
      check_eq("upclamp_yt", 32'(yt), 32'd0);

      // down held, reset in cycle 40 (mid-REPEAT): fresh press step at 49, repeat at 69
      clear_pulses();
      down_b = 1'b1;
      for (int c = 0; c < 70; c++) begin
         rst = (c == 40);
         tick(c + 1);
         if (c + 1 == 40) check_eq("prerst_yb", 32'(yb), 32'd132);
         if (c + 1 == 41) begin
            check_eq("midrst_xb", 32'(xb), 32'd512);
            check_eq("midrst_yb", 32'(yb), 32'd384);
            check_eq("midrst_yt", 32'(yt), 32'd284);
            check_eq("midrst_mv", 32'(mv), 32'd0);
         end
      end
      rst = 1'b0;
      check_eq("rsthold_pulses", 32'(pulse_cnt), 32'd6);
      check_eq("rsthold_p3", 32'(pulse_at[3]), 32'd38);
      check_eq("rsthold_p4", 32'(pulse_at[4]), 32'd49);
      check_eq("rsthold_p5", 32'(pulse_at[5]), 32'd69);
      check_eq("rsthold_yb", 32'(yb), 32'd400);
      check_eq("rsthold_zt", 32'(zt), 32'd1000);
      down_b = 1'b0;
      for (int c = 0; c < 20; c++) tick(c + 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
